mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 16 +
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int unsigned ITERATIONS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle shift-add multiplier and restoring divider sharing one
// 64-bit working register; signed ops run on magnitudes and fix signs at the end.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

    logic [1:0]         state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] acc_step;
    logic               sign_a;
    logic               sign_b;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_d      = a_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        // Multiplier sits in acc low half and shifts out LSB-first.
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {add_sum, acc_q[WIDTH-1:1]};

        // Restoring step: remainder in acc high half, quotient bits enter at LSB.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opb_q};
        div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

        acc_step = (state_q == ST_MUL) ? mul_step : div_step;
        sign_a   = ~op[0] & operandA[WIDTH-1];
        sign_b   = ~op[0] & operandB[WIDTH-1];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d      = operandA;
                    acc_d    = {{WIDTH{1'b0}}, sign_a ? -operandA : operandA};
                    opb_d    = sign_b ? -operandB : operandB;
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = op[1] ? sign_a : (sign_a ^ sign_b);
                    count_d  = '0;
                    dbz_d    = 1'b0;
                    state_d  = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d   = acc_step;
                count_d = count_q + 6'd1;
                if (count_q == LAST_COUNT) begin
                    state_d = ST_DONE;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = neg_lo_q ? -acc_step : acc_step;
                    end else if (opb_q == '0) begin
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_lo_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
                        hi_d = neg_hi_q ? -acc_step[2*WIDTH-1:WIDTH]
                                        : acc_step[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done      = (state_q == ST_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, signed/unsigned results,
// divide-by-zero, back-to-back starts and reset abort.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .divByZero(divByZero)
    );

    always #5 clock = ~clock;

    // One-cycle start pulse; returns at the falling edge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts busy cycles until done is seen, bounded at 40 cycles.
    task automatic wait_done(output int busy_cycles, output bit got);
        int i = 0;
        busy_cycles = 0;
        while (i < 40 && done !== 1'b1) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clock);
            i++;
        end
        got = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; operandA = '0; operandB = '0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h_%h exp 0", hi, lo); end
        checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b exp 0", divByZero); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int bc; bit got;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(bc, got);
        checks++; if (!got) begin errors++; $display("FAIL mult_done got 0 exp 1"); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mult_latency got %0d exp 32", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %0b exp 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %0b exp 0", done); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo_hold got %h exp fffffffa", lo); end
        // Both operands negative: -5 * -6 = 30
        issue(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        wait_done(bc, got);
        checks++; if ({hi, lo} !== 64'd30) begin errors++; $display("FAIL mult_negneg got %h_%h exp 0_1e", hi, lo); end
    endtask

    task automatic test_multu();
        int bc; bit got;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, got);
        checks++; if (!got || bc !== 32) begin errors++; $display("FAIL multu_latency got %0d done %0b exp 32 1", bc, got); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    endtask

    task automatic test_div();
        int bc; bit got;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(bc, got);
        checks++; if (!got || bc !== 32) begin errors++; $display("FAIL div_latency got %0d done %0b exp 32 1", bc, got); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL div_dbz got %0b exp 0", divByZero); end
        // 7 / -2 = -3 rem 1
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(bc, got);
        checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_negdivisor got %h_%h exp 00000001_fffffffd", hi, lo); end
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(bc, got);
        checks++; if (!got || bc !== 32) begin errors++; $display("FAIL divz_latency got %0d done %0b exp 32 1", bc, got); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
        checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divz_hi got %h exp 00000007", hi); end
        checks++; if (divByZero !== 1'b1) begin errors++; $display("FAIL divz_flag got %0b exp 1", divByZero); end
        repeat (3) @(negedge clock);
        checks++; if (divByZero !== 1'b1) begin errors++; $display("FAIL divz_flag_hold got %0b exp 1", divByZero); end
        // Signed divide by zero keeps the raw dividend in hi
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done(bc, got);
        checks++; if ({hi, lo, divByZero} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}) begin
            errors++; $display("FAIL divz_signed got %h_%h %0b exp fffffff9_ffffffff 1", hi, lo, divByZero); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc, got);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
        checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL div_ovf_dbz got %0b exp 0", divByZero); end
    endtask

    task automatic test_back_to_back();
        int bc; bit got; int total;
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(bc, got);
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL b2b_first got %h exp 0000000f", lo); end
        start = 1'b1; op = OP_DIVU; operandA = 32'd100; operandB = 32'd7;
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got busy %0b exp 1", busy); end
        total = 0;
        repeat (5) begin
            if (busy === 1'b1) total++;
            @(negedge clock);
        end
        start = 1'b1; op = OP_MULT; operandA = 32'h1234; operandB = 32'h99;
        if (busy === 1'b1) total++;
        @(negedge clock);
        start = 1'b0;
        wait_done(bc, got);
        total += bc;
        checks++; if (!got || total !== 32) begin errors++; $display("FAIL b2b_latency got %0d done %0b exp 32 1", total, got); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo got %h exp 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h exp 00000002", hi); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %0b done %0b exp 0 0", busy, done); end
    endtask

    task automatic test_reset_abort();
        int bc; bit got; bit seen;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        repeat (9) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %0b exp 1", busy); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo got %h_%h exp 0", hi, lo); end
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            if (done !== 1'b0) seen = 1'b1;
            @(negedge clock);
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_done got 1 exp 0"); end
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(bc, got);
        checks++; if (!got || bc !== 32) begin errors++; $display("FAIL abort_restart_latency got %0d done %0b exp 32 1", bc, got); end
        checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL abort_restart got %h_%h exp 0_2a", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
